// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    EXPIRE = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Layout of the 9-bit seconds word handed to the segment display.
  localparam int ACTIVE_BIT = 8;
  localparam int TENS_HI    = 7;
  localparam int TENS_LO    = 4;
  localparam int ONES_HI    = 3;
  localparam int ONES_LO    = 0;

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts enabled cycles, pulses tick on the last cycle of each period.
// Latency: tick is combinational from the count and enable; count updates one edge later.
// Backpressure: none; en=0 freezes the count, clr (higher priority) returns it to 0.
//
// Ports: clk, reset (async active-low), en (count this cycle), clr (sync clear),
//        tick (high in the enabled cycle where the count is TICK_CYCLES-1).
module tick_gen #(
  parameter int TICK_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_wrap;

  assign at_wrap = (cnt_q == CNT_W'(TICK_CYCLES - 1));
  assign tick    = en && at_wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Two-digit BCD countdown timer with pause, cancel, retrigger and a one-cycle expiry pulse.
// Latency: start/cancel/tick visible on seconds/busy/expired right after the sampling edge.
// Backpressure: none; pause freezes prescaler and count, cancel overrides everything.
//
// Ports: clk, reset (async active-low), start (pulse, loads preset), preset (BCD {tens,ones}),
//        cancel (pulse), pause (level), seconds ({active, tens, ones}), expired (pulse), busy.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the last preset after every expiry.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int TICK_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] preset,
  input  logic       cancel,
  input  logic       pause,
  output logic [8:0] seconds,
  output logic       expired,
  output logic       busy
);

  // Digits above 9 saturate to 9 so the display never sees a non-BCD code.
  function automatic bcd2_t bcd_clamp(input bcd2_t v);
    bcd_digit_t t;
    bcd_digit_t o;
    t = v[7:4];
    o = v[3:0];
    if (t > BCD_MAX_DIGIT) t = BCD_MAX_DIGIT;
    if (o > BCD_MAX_DIGIT) o = BCD_MAX_DIGIT;
    return {t, o};
  endfunction

  // Never called with 00: reaching 00 diverts to EXPIRE first, so no 99 wrap.
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end
    return {v[7:4] - 4'd1, BCD_MAX_DIGIT};
  endfunction

  state_e state_q, state_d;
  bcd2_t  count_q, count_d;
  logic   busy_q, busy_d;
  logic   expired_q, expired_d;
  logic   presc_en, presc_clr, tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  bcd2_t  last_preset_q, last_preset_d;
`endif

  // The enable depends only on inputs and state (never on tick) to keep the
  // prescaler path free of combinational loops. HOLD counts again in the cycle
  // pause drops, so a pause of N cycles delays expiry by exactly N cycles.
  always_comb begin
    presc_clr = cancel || start;
    presc_en  = 1'b0;
    if (!cancel && !start && !pause) begin
      case (state_q)
        RUN, HOLD: presc_en = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // The expiry cycle is the first cycle of the reloaded second.
        EXPIRE:    presc_en = 1'b1;
`endif
        default:   presc_en = 1'b0;
      endcase
    end
  end

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    last_preset_d = last_preset_q;
`endif
    if (cancel) begin
      state_d = IDLE;
      count_d = 8'h00;
    end else if (start) begin
      count_d = bcd_clamp(preset);
      state_d = (count_d == 8'h00) ? EXPIRE : RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      last_preset_d = count_d;
`endif
    end else begin
      case (state_q)
        RUN, HOLD: begin
          if (pause) begin
            state_d = HOLD;
          end else if (tick) begin
            count_d = bcd_dec(count_q);
            state_d = (count_d == 8'h00) ? EXPIRE : RUN;
          end else begin
            state_d = RUN;
          end
        end
        EXPIRE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count_d = last_preset_q;
          state_d = (last_preset_q == 8'h00) ? EXPIRE : RUN;
`else
          count_d = 8'h00;
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    expired_d = (state_d == EXPIRE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    busy_d = (state_d != IDLE);
`else
    busy_d = (state_d == RUN) || (state_d == HOLD);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 8'h00;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_preset_q <= 8'h00;
    end else begin
      last_preset_q <= last_preset_d;
    end
  end
`endif

  assign seconds[ACTIVE_BIT]      = busy_q;
  assign seconds[TENS_HI:TENS_LO] = count_q[7:4];
  assign seconds[ONES_HI:ONES_LO] = count_q[3:0];
  assign expired                  = expired_q;
  assign busy                     = busy_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
module tb_countdown_timer_bcd;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [8:0] seconds;
  logic       expired;
  logic       busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd #(
    .TICK_CYCLES (TICK),
    .CNT_W       (3)
  ) dut (
    .clk     (clk),
    .reset   (reset_n),
    .start   (start),
    .preset  (preset),
    .cancel  (cancel),
    .pause   (pause),
    .seconds (seconds),
    .expired (expired),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p);
    start  = 1'b1;
    preset = p;
    step();
    start  = 1'b0;
    preset = 8'hEE;  // garbage outside the start cycle must be ignored
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  typedef struct {
    logic [7:0] p;
    logic [8:0] first;
    logic [8:0] after_tick;
    logic       exp_after;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int at;
    int elapsed;
    logic seen;
    logic frozen;
    logic [8:0] exp_sec;

    vecs[0] = '{8'h03, 9'h103, 9'h102, 1'b0};
    vecs[1] = '{8'h10, 9'h110, 9'h109, 1'b0};
    vecs[2] = '{8'hAF, 9'h199, 9'h198, 1'b0};
    vecs[3] = '{8'hA3, 9'h193, 9'h192, 1'b0};
    vecs[4] = '{8'h42, 9'h142, 9'h141, 1'b0};
    vecs[5] = '{8'h3A, 9'h139, 9'h138, 1'b0};
    vecs[6] = '{8'h99, 9'h199, 9'h198, 1'b0};
    vecs[7] = '{8'h01, 9'h000, 9'h000, 1'b1};
    vecs[7].first = 9'h101;

    // Reset state, including a start attempt while reset is held.
    #3;
    chk("rst_seconds", 32'(seconds), 32'h000);
    chk("rst_expired", 32'(expired), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    start = 1'b1;
    preset = 8'h05;
    step();
    start = 1'b0;
    chk("rst_hold_start", 32'(seconds), 32'h000);
    reset_n = 1'b1;
    step();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto reload: preset 02 expires every 8 cycles and busy never drops.
    do_start(8'h02);
    chk("auto_load", 32'(seconds), 32'h102);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("auto_expired_%0d", k), 32'(expired), 32'((k % 8) == 0));
      chk($sformatf("auto_busy_%0d", k), 32'(busy), 32'h1);
      if (k == 8) chk("auto_exp_word", 32'(seconds), 32'h100);
      if (k == 9) chk("auto_reload_word", 32'(seconds), 32'h102);
    end
    do_cancel();
    chk("auto_cancel_busy", 32'(busy), 32'h0);
    chk("auto_cancel_seconds", 32'(seconds), 32'h000);
`else
    // Table: load value after start, held value, value after first tick.
    for (int i = 0; i < 8; i++) begin
      do_start(vecs[i].p);
      chk($sformatf("load_%0d", i), 32'(seconds), 32'(vecs[i].first));
      chk($sformatf("load_busy_%0d", i), 32'(busy), 32'h1);
      repeat (TICK - 1) step();
      chk($sformatf("hold_%0d", i), 32'(seconds), 32'(vecs[i].first));
      step();
      chk($sformatf("tick_%0d", i), 32'(seconds), 32'(vecs[i].after_tick));
      chk($sformatf("tick_exp_%0d", i), 32'(expired), 32'(vecs[i].exp_after));
      do_cancel();
      chk($sformatf("clr_%0d", i), 32'(seconds), 32'h000);
    end

    // Basic countdown from 03: expiry 12 cycles after start, one cycle wide.
    do_start(8'h03);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_sec = (k < 4) ? 9'h103 : (k < 8) ? 9'h102 : (k < 12) ? 9'h101 : 9'h000;
      chk($sformatf("basic_sec_%0d", k), 32'(seconds), 32'(exp_sec));
      chk($sformatf("basic_exp_%0d", k), 32'(expired), 32'(k == 12));
    end
    chk("basic_busy_at_exp", 32'(busy), 32'h0);
    step();
    chk("basic_exp_width", 32'(expired), 32'h0);
    chk("basic_idle_busy", 32'(busy), 32'h0);
    chk("basic_idle_sec", 32'(seconds), 32'h000);

    // Tens borrow: 10 -> 09 ... never shows 100, expires after 40 cycles.
    do_start(8'h10);
    seen = 1'b0;
    at = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (seconds == 9'h100) seen = 1'b1;
      if (expired && at == 0) at = k;
      if (at != 0) break;
    end
    chk("borrow_no_100", 32'(seen), 32'h0);
    chk("borrow_expire_at", 32'(at), 32'd40);

    // Pause 10 cycles mid-second: expiry moves from 20 to 30 cycles.
    do_start(8'h05);
    repeat (6) step();
    chk("pause_before", 32'(seconds), 32'h104);
    pause = 1'b1;
    frozen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (seconds !== 9'h104 || busy !== 1'b1) frozen = 1'b0;
    end
    pause = 1'b0;
    chk("pause_frozen", 32'(frozen), 32'h1);
    elapsed = 16;
    for (int k = 0; k < 40; k++) begin
      step();
      elapsed++;
      if (expired) break;
    end
    chk("pause_expire_at", 32'(elapsed), 32'd30);

    // Cancel in RUN at 07: IDLE, blank word, no expiry pulse afterwards.
    do_start(8'h07);
    chk("cancel_load", 32'(seconds), 32'h107);
    do_cancel();
    chk("cancel_sec", 32'(seconds), 32'h000);
    chk("cancel_busy", 32'(busy), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (expired) seen = 1'b1;
    end
    chk("cancel_no_exp", 32'(seen), 32'h0);

    // Start and cancel together: cancel wins.
    start = 1'b1;
    cancel = 1'b1;
    preset = 8'h05;
    step();
    start = 1'b0;
    cancel = 1'b0;
    chk("sc_busy", 32'(busy), 32'h0);
    chk("sc_sec", 32'(seconds), 32'h000);
    step();
    chk("sc_sec_later", 32'(seconds), 32'h000);

    // Retrigger mid-countdown and from HOLD.
    do_start(8'h05);
    repeat (5) step();
    chk("retrig_before", 32'(seconds), 32'h104);
    do_start(8'h42);
    chk("retrig_load", 32'(seconds), 32'h142);
    chk("retrig_no_exp", 32'(expired), 32'h0);
    pause = 1'b1;
    repeat (2) step();
    do_start(8'h21);
    chk("retrig_hold", 32'(seconds), 32'h121);
    pause = 1'b0;
    do_cancel();

    // Zero preset: expiry pulse right after the start edge.
    do_start(8'h00);
    chk("zero_exp", 32'(expired), 32'h1);
    chk("zero_sec", 32'(seconds), 32'h000);
    chk("zero_busy", 32'(busy), 32'h0);
    step();
    chk("zero_exp_width", 32'(expired), 32'h0);

    // Asynchronous reset away from the clock edge.
    do_start(8'h05);
    step();
    chk("arst_before", 32'(seconds), 32'h105);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sec", 32'(seconds), 32'h000);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_exp", 32'(expired), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_after_sec", 32'(seconds), 32'h000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
